// File: rtl/ct_lsu_dcache_tagdirty_wr_arb_pkg.sv
// Shared LSU dcache array-arbiter definitions: requester encoding, array widths, write payload.
package ct_lsu_dcache_tagdirty_wr_arb_pkg;

  localparam int unsigned DC_TAG_W   = 26;
  localparam int unsigned DC_DIRTY_W = 7;
  localparam int unsigned IDX_W      = 9;
  localparam int unsigned DC_WAYS    = 2;
  localparam int unsigned TAG_DIN_W  = DC_WAYS * DC_TAG_W;
  localparam int unsigned REQ_SEL_W  = 2;

  localparam logic [REQ_SEL_W-1:0] SNQ = 2'd0;
  localparam logic [REQ_SEL_W-1:0] RB  = 2'd1;
  localparam logic [REQ_SEL_W-1:0] ICC = 2'd2;

  // Per-requester array write payload (index travels separately, its width is per-instance)
  typedef struct packed {
    logic [DC_WAYS-1:0]    tag_wen;
    logic [TAG_DIN_W-1:0]  tag_din;
    logic [DC_DIRTY_W-1:0] dirty_wen;
    logic [DC_DIRTY_W-1:0] dirty_din;
  } wr_pld_t;

endpackage

// File: rtl/ct_lsu_dcache_arb_age.sv
// Saturating age counter for a low-priority requester; flags promotion once it has waited AGE_MAX slots.
module ct_lsu_dcache_arb_age #(
  parameter int unsigned AGE_MAX = 7
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic busy_i,
  input  logic req_i,
  input  logic grnt_i,
  output logic promote_o
);

  localparam int unsigned AGE_W = 3;

  logic [AGE_W-1:0] age_q;
  logic [AGE_W-1:0] age_d;
  logic             promote_q;
  logic             promote_d;

  // Count slots lost to higher-priority requesters; busy cycles are not lost slots
  always_comb begin
    age_d = age_q;
    if (grnt_i) begin
      age_d = '0;
    end else if (req_i && !busy_i && (age_q != AGE_W'(AGE_MAX))) begin
      age_d = age_q + AGE_W'(1);
    end
    promote_d = (age_d == AGE_W'(AGE_MAX));
  end

  // Counter and promotion flag registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      age_q     <= '0;
      promote_q <= 1'b0;
    end else begin
      age_q     <= age_d;
      promote_q <= promote_d;
    end
  end

  assign promote_o = promote_q;

endmodule

// File: rtl/ct_lsu_dcache_tagdirty_wr_arb.sv
// Tag/dirty array write-port arbiter: snq > rb > icc with icc age promotion, one registered write slot.
module ct_lsu_dcache_tagdirty_wr_arb #(
  parameter int unsigned IDX_W   = 9,
  parameter int unsigned AGE_MAX = 7
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst,
  input  logic             dcache_arb_busy,
  input  logic             snq_req,
  input  logic             rb_req,
  input  logic             icc_req,
  input  logic [IDX_W-1:0] snq_idx,
  input  logic [IDX_W-1:0] rb_idx,
  input  logic [IDX_W-1:0] icc_idx,
  input  logic [1:0]       snq_tag_wen,
  input  logic [1:0]       rb_tag_wen,
  input  logic [1:0]       icc_tag_wen,
  input  logic [51:0]      snq_tag_din,
  input  logic [51:0]      rb_tag_din,
  input  logic [51:0]      icc_tag_din,
  input  logic [6:0]       snq_dirty_wen,
  input  logic [6:0]       rb_dirty_wen,
  input  logic [6:0]       icc_dirty_wen,
  input  logic [6:0]       snq_dirty_din,
  input  logic [6:0]       rb_dirty_din,
  input  logic [6:0]       icc_dirty_din,
  output logic             snq_grnt,
  output logic             rb_grnt,
  output logic             icc_grnt,
  output logic             dcache_tag_gwen,
  output logic [1:0]       dcache_tag_wen,
  output logic [51:0]      dcache_tag_din,
  output logic             dcache_dirty_gwen,
  output logic [6:0]       dcache_dirty_wen,
  output logic [6:0]       dcache_dirty_din,
  output logic [IDX_W-1:0] dcache_idx,
  output logic             compare_dcwp_sw_inst
);

  import ct_lsu_dcache_tagdirty_wr_arb_pkg::*;

  wr_pld_t              snq_pld_c;
  wr_pld_t              rb_pld_c;
  wr_pld_t              icc_pld_c;
  wr_pld_t              win_pld_c;
  logic [IDX_W-1:0]     win_idx_c;
  logic [REQ_SEL_W-1:0] sel_c;
  logic                 grnt_c;
  logic                 icc_promote;

  logic                 tag_gwen_q;
  logic                 dirty_gwen_q;
  logic                 sw_inst_q;
  logic [IDX_W-1:0]     idx_q;
  wr_pld_t              pld_q;

  assign snq_pld_c = '{tag_wen: snq_tag_wen, tag_din: snq_tag_din,
                       dirty_wen: snq_dirty_wen, dirty_din: snq_dirty_din};
  assign rb_pld_c  = '{tag_wen: rb_tag_wen, tag_din: rb_tag_din,
                       dirty_wen: rb_dirty_wen, dirty_din: rb_dirty_din};
  assign icc_pld_c = '{tag_wen: icc_tag_wen, tag_din: icc_tag_din,
                       dirty_wen: icc_dirty_wen, dirty_din: icc_dirty_din};

  // icc starvation tracking
  ct_lsu_dcache_arb_age #(
    .AGE_MAX (AGE_MAX)
  ) u_age (
    .clk_i     (forever_cpuclk),
    .rst_i     (cpurst),
    .busy_i    (dcache_arb_busy),
    .req_i     (icc_req),
    .grnt_i    (icc_grnt),
    .promote_o (icc_promote)
  );

  // Pick one winner per free slot; a promoted icc jumps ahead of snq and rb
  always_comb begin
    sel_c  = SNQ;
    grnt_c = 1'b0;
    if (!cpurst && !dcache_arb_busy) begin
      if (icc_promote && icc_req) begin
        sel_c  = ICC;
        grnt_c = 1'b1;
      end else if (snq_req) begin
        sel_c  = SNQ;
        grnt_c = 1'b1;
      end else if (rb_req) begin
        sel_c  = RB;
        grnt_c = 1'b1;
      end else if (icc_req) begin
        sel_c  = ICC;
        grnt_c = 1'b1;
      end
    end
  end

  assign snq_grnt = grnt_c && (sel_c == SNQ);
  assign rb_grnt  = grnt_c && (sel_c == RB);
  assign icc_grnt = grnt_c && (sel_c == ICC);

  // Winner payload mux
  always_comb begin
    win_pld_c = snq_pld_c;
    win_idx_c = snq_idx;
    case (sel_c)
      RB: begin
        win_pld_c = rb_pld_c;
        win_idx_c = rb_idx;
      end
      ICC: begin
        win_pld_c = icc_pld_c;
        win_idx_c = icc_idx;
      end
      default: begin
        win_pld_c = snq_pld_c;
        win_idx_c = snq_idx;
      end
    endcase
  end

  // Write stage: strobes live for one cycle per grant, payload holds between grants
  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      tag_gwen_q   <= 1'b0;
      dirty_gwen_q <= 1'b0;
      sw_inst_q    <= 1'b0;
      idx_q        <= '0;
      pld_q        <= '0;
    end else begin
      tag_gwen_q   <= grnt_c && (|win_pld_c.tag_wen);
      dirty_gwen_q <= grnt_c && (|win_pld_c.dirty_wen);
      sw_inst_q    <= icc_grnt;
      if (grnt_c) begin
        idx_q <= win_idx_c;
        pld_q <= win_pld_c;
      end
    end
  end

  assign dcache_tag_gwen      = tag_gwen_q;
  assign dcache_dirty_gwen    = dirty_gwen_q;
  assign compare_dcwp_sw_inst = sw_inst_q;
  assign dcache_idx           = idx_q;
  assign dcache_tag_wen       = pld_q.tag_wen;
  assign dcache_tag_din       = pld_q.tag_din;
  assign dcache_dirty_wen     = pld_q.dirty_wen;
  assign dcache_dirty_din     = pld_q.dirty_din;

endmodule

// File: tb/tb_ct_lsu_dcache_tagdirty_wr_arb.sv
// Bench for the tag/dirty write arbiter: vector table plus corner-case sequences, scoreboarded write stage.
module tb_ct_lsu_dcache_tagdirty_wr_arb;

  logic        clk;
  logic        rst;
  logic        busy;
  logic        snq_req, rb_req, icc_req;
  logic [8:0]  snq_idx, rb_idx, icc_idx;
  logic [1:0]  snq_tag_wen, rb_tag_wen, icc_tag_wen;
  logic [51:0] snq_tag_din, rb_tag_din, icc_tag_din;
  logic [6:0]  snq_dirty_wen, rb_dirty_wen, icc_dirty_wen;
  logic [6:0]  snq_dirty_din, rb_dirty_din, icc_dirty_din;
  logic        snq_grnt, rb_grnt, icc_grnt;
  logic        tag_gwen, dirty_gwen, sw_inst;
  logic [1:0]  tag_wen;
  logic [51:0] tag_din;
  logic [6:0]  dirty_wen, dirty_din;
  logic [8:0]  idx;

  typedef struct packed {
    logic [8:0]  idx;
    logic [1:0]  tw;
    logic [51:0] td;
    logic [6:0]  dw;
    logic [6:0]  dd;
  } pld_t;

  typedef struct {
    logic tag_gwen;
    logic dirty_gwen;
    logic sw;
    pld_t p;
  } exp_t;

  typedef struct {
    logic b, s, r, i;
    int   sel;
  } vec_t;

  pld_t st[3];
  exp_t sb_q[$];
  exp_t last_wr;
  vec_t vecs[12];
  int   checks = 0;
  int   errors = 0;

  ct_lsu_dcache_tagdirty_wr_arb dut (
    .forever_cpuclk       (clk),
    .cpurst               (rst),
    .dcache_arb_busy      (busy),
    .snq_req              (snq_req),
    .rb_req               (rb_req),
    .icc_req              (icc_req),
    .snq_idx              (snq_idx),
    .rb_idx               (rb_idx),
    .icc_idx              (icc_idx),
    .snq_tag_wen          (snq_tag_wen),
    .rb_tag_wen           (rb_tag_wen),
    .icc_tag_wen          (icc_tag_wen),
    .snq_tag_din          (snq_tag_din),
    .rb_tag_din           (rb_tag_din),
    .icc_tag_din          (icc_tag_din),
    .snq_dirty_wen        (snq_dirty_wen),
    .rb_dirty_wen         (rb_dirty_wen),
    .icc_dirty_wen        (icc_dirty_wen),
    .snq_dirty_din        (snq_dirty_din),
    .rb_dirty_din         (rb_dirty_din),
    .icc_dirty_din        (icc_dirty_din),
    .snq_grnt             (snq_grnt),
    .rb_grnt              (rb_grnt),
    .icc_grnt             (icc_grnt),
    .dcache_tag_gwen      (tag_gwen),
    .dcache_tag_wen       (tag_wen),
    .dcache_tag_din       (tag_din),
    .dcache_dirty_gwen    (dirty_gwen),
    .dcache_dirty_wen     (dirty_wen),
    .dcache_dirty_din     (dirty_din),
    .dcache_idx           (idx),
    .compare_dcwp_sw_inst (sw_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_age(input string nm, input logic [2:0] exp);
    chk(nm, 64'(dut.u_age.age_q), 64'(exp));
  endtask

  task automatic rand_pld();
    for (int k = 0; k < 3; k++) begin
      st[k].idx = 9'($urandom);
      st[k].tw  = 2'($urandom);
      st[k].td  = {20'($urandom), 32'($urandom)};
      st[k].dw  = 7'($urandom);
      st[k].dd  = 7'($urandom);
    end
  endtask

  task automatic sb_reset();
    sb_q.delete();
    last_wr = '{tag_gwen: 1'b0, dirty_gwen: 1'b0, sw: 1'b0, p: '0};
    sb_q.push_back(last_wr);
  endtask

  // One arbitration cycle: check last slot's write, drive new requests, check grants, predict next write
  task automatic cycle(input logic b, input logic s, input logic r, input logic i,
                       input int sel, input string nm);
    exp_t e;
    @(negedge clk);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb_q.pop_front();
      chk({nm, ".tag_gwen"},   64'(tag_gwen),   64'(e.tag_gwen));
      chk({nm, ".dirty_gwen"}, 64'(dirty_gwen), 64'(e.dirty_gwen));
      chk({nm, ".sw_inst"},    64'(sw_inst),    64'(e.sw));
      chk({nm, ".idx"},        64'(idx),        64'(e.p.idx));
      chk({nm, ".tag_wen"},    64'(tag_wen),    64'(e.p.tw));
      chk({nm, ".tag_din"},    64'(tag_din),    64'(e.p.td));
      chk({nm, ".dirty_wen"},  64'(dirty_wen),  64'(e.p.dw));
      chk({nm, ".dirty_din"},  64'(dirty_din),  64'(e.p.dd));
    end
    busy = b; snq_req = s; rb_req = r; icc_req = i;
    {snq_idx, snq_tag_wen, snq_tag_din, snq_dirty_wen, snq_dirty_din} = st[0];
    {rb_idx,  rb_tag_wen,  rb_tag_din,  rb_dirty_wen,  rb_dirty_din}  = st[1];
    {icc_idx, icc_tag_wen, icc_tag_din, icc_dirty_wen, icc_dirty_din} = st[2];
    #1;
    chk({nm, ".grnt"}, 64'({icc_grnt, rb_grnt, snq_grnt}),
        (sel == 0) ? 64'd0 : (64'd1 << (sel - 1)));
    if (sel == 0) begin
      e = last_wr;
      e.tag_gwen = 1'b0; e.dirty_gwen = 1'b0; e.sw = 1'b0;
    end else begin
      e.p = st[sel-1];
      e.tag_gwen   = |e.p.tw;
      e.dirty_gwen = |e.p.dw;
      e.sw         = (sel == 3);
      last_wr      = e;
    end
    sb_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; busy = 1'b0;
    snq_req = 1'b1; rb_req = 1'b1; icc_req = 1'b1;
    rand_pld();
    {snq_idx, snq_tag_wen, snq_tag_din, snq_dirty_wen, snq_dirty_din} = st[0];
    {rb_idx,  rb_tag_wen,  rb_tag_din,  rb_dirty_wen,  rb_dirty_din}  = st[1];
    {icc_idx, icc_tag_wen, icc_tag_din, icc_dirty_wen, icc_dirty_din} = st[2];

    // Reset state, grants forced low even with requests pending
    #12;
    chk("rst.grnt", 64'({icc_grnt, rb_grnt, snq_grnt}), 64'd0);
    chk("rst.gwen", 64'({tag_gwen, dirty_gwen, sw_inst}), 64'd0);
    chk("rst.idx", 64'(idx), 64'd0);
    chk("rst.tag_din", 64'(tag_din), 64'd0);
    chk_age("rst.age", 3'd0);
    snq_req = 1'b0; rb_req = 1'b0; icc_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sb_reset();

    // Single rb request with fixed payload, write lasts one cycle
    rand_pld();
    st[1].idx = 9'h1A5; st[1].tw = 2'b01; st[1].dw = 7'h07; st[1].dd = 7'h01;
    cycle(0, 0, 1, 0, 2, "single_rb");
    cycle(0, 0, 0, 0, 0, "single_wr");
    cycle(0, 0, 0, 0, 0, "single_idle");

    // Vector table
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 2};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 0};
    for (int v = 0; v < 12; v++) begin
      rand_pld();
      cycle(vecs[v].b, vecs[v].s, vecs[v].r, vecs[v].i, vecs[v].sel, $sformatf("vec%0d", v));
    end

    // Starvation: snq wins 7 slots, 8th slot goes to promoted icc ahead of snq
    for (int k = 0; k < 7; k++) begin
      rand_pld();
      cycle(0, 1, 1, 1, 1, $sformatf("starve%0d", k));
    end
    rand_pld();
    cycle(0, 1, 1, 1, 3, "starve_promote");
    chk_age("starve.age_sat", 3'd7);
    @(posedge clk); #1;
    chk_age("starve.age_clr", 3'd0);
    rand_pld();
    cycle(0, 1, 1, 0, 1, "starve_after");

    // Busy stall: counter frozen, grant on first free cycle; then saturate and hold under busy
    for (int k = 0; k < 3; k++) begin
      rand_pld();
      cycle(0, 1, 0, 1, 1, $sformatf("pre_busy%0d", k));
    end
    for (int k = 0; k < 5; k++) begin
      rand_pld();
      cycle(1, 1, 0, 1, 0, $sformatf("busy%0d", k));
    end
    rand_pld();
    cycle(0, 1, 0, 1, 1, "busy_drop");
    chk_age("busy.age_frozen", 3'd3);
    for (int k = 0; k < 3; k++) begin
      rand_pld();
      cycle(0, 1, 0, 1, 1, $sformatf("to_sat%0d", k));
    end
    for (int k = 0; k < 2; k++) begin
      rand_pld();
      cycle(1, 1, 0, 1, 0, $sformatf("sat_busy%0d", k));
    end
    rand_pld();
    cycle(0, 1, 0, 1, 3, "sat_grant");
    chk_age("sat.age_hold", 3'd7);

    // Dirty-only write, then a zero-enable grant that consumes the slot silently
    rand_pld();
    st[0].tw = 2'b00; st[0].dw = 7'h38;
    cycle(0, 1, 0, 0, 1, "dirty_only");
    rand_pld();
    st[1].tw = 2'b00; st[1].dw = 7'h00;
    cycle(0, 0, 1, 0, 2, "zero_en");

    // Back-to-back grants to the same index
    rand_pld();
    st[0].idx = 9'h0F0; st[1].idx = 9'h0F0;
    cycle(0, 1, 1, 0, 1, "b2b_snq");
    cycle(0, 0, 1, 0, 2, "b2b_rb");
    cycle(0, 0, 0, 0, 0, "b2b_idle");

    // Reset while a write is pending in the write stage
    rand_pld();
    st[0].idx = 9'h155; st[0].tw = 2'b11; st[0].dw = 7'h7F;
    cycle(0, 1, 0, 1, 1, "rstmid_grant");
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rstmid.gwen", 64'({tag_gwen, dirty_gwen, sw_inst}), 64'd0);
    chk("rstmid.idx", 64'(idx), 64'd0);
    chk("rstmid.grnt", 64'({icc_grnt, rb_grnt, snq_grnt}), 64'd0);
    chk_age("rstmid.age", 3'd0);
    snq_req = 1'b0; icc_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sb_reset();
    rand_pld();
    cycle(0, 0, 0, 0, 0, "post_rst_idle");
    cycle(0, 0, 0, 0, 0, "flush");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ct_lsu_dcache_tagdirty_wr_arb.md
# ct_lsu_dcache_tagdirty_wr_arb

Write-port arbiter for the LSU dcache tag and dirty arrays. Three requesters share a single write slot per cycle: snoop queue, refill buffer and icc set&way maintenance. The block grants one of them and registers the winning index, way-enables and data onto the array write bus. That same bus also feeds the dcache watchpoint compare logic, which uses `compare_dcwp_sw_inst` to tell set&way writes apart from normal ones.

## Interface
Parameters:
- `IDX_W`, default 9: dcache index width (64K configuration).
- `AGE_MAX`, default 7: number of deferred cycles after which icc is promoted to top priority.

Ports:
- `forever_cpuclk`  in  1  clock
- `cpurst`  in  1  asynchronous, active-high reset
- `dcache_arb_busy`  in  1  array port held by the load/store read pipeline; no grant while high
- `snq_req` / `rb_req` / `icc_req`  in  1 each  write request; held until granted
- `snq_idx` / `rb_idx` / `icc_idx`  in  IDX_W each  target set
- `snq_tag_wen` / `rb_tag_wen` / `icc_tag_wen`  in  2 each  per-way tag write enable
- `snq_tag_din` / `rb_tag_din` / `icc_tag_din`  in  52 each  tag data, way1 in [51:26], way0 in [25:0]
- `snq_dirty_wen` / `rb_dirty_wen` / `icc_dirty_wen`  in  7 each  dirty-array bit enables
- `snq_dirty_din` / `rb_dirty_din` / `icc_dirty_din`  in  7 each  dirty-array data
- `snq_grnt` / `rb_grnt` / `icc_grnt`  out  1 each  combinational grant, same cycle as request
- `dcache_tag_gwen`  out  1  tag write this cycle (high = write)
- `dcache_tag_wen`  out  2  registered tag way enables
- `dcache_tag_din`  out  52  registered tag data
- `dcache_dirty_gwen`  out  1  dirty write this cycle (high = write)
- `dcache_dirty_wen`  out  7  registered dirty enables
- `dcache_dirty_din`  out  7  registered dirty data
- `dcache_idx`  out  IDX_W  registered index
- `compare_dcwp_sw_inst`  out  1  current write originates from icc set&way

## Operation
- **Default priority:** snq > rb > icc.
- **Grant condition:** a request is granted only when `dcache_arb_busy` = 0. At most one grant per cycle, one-hot.
- **icc age counter** (3-bit, saturating at `AGE_MAX`):
  - increments in every cycle where `icc_req` = 1, `icc_grnt` = 0 and `dcache_arb_busy` = 0;
  - clears on `icc_grnt`.
- **icc promotion:** when the age counter equals `AGE_MAX`, icc becomes top priority for its next grant. snq and rb then wait one slot.
- **Write-stage capture:** on a grant, the winner's idx, wen and din are captured into the write-stage registers.
  - `dcache_tag_gwen` = |tag_wen of the winner.
  - `dcache_dirty_gwen` = |dirty_wen of the winner.
  - A granted request with all enables zero consumes the slot, but both gwen outputs stay 0.
- **`compare_dcwp_sw_inst`** = 1 exactly when the registered write came from icc.
- **No-grant cycles:** in a cycle with no grant, both gwen outputs and `compare_dcwp_sw_inst` deassert. The data, wen and idx registers hold their previous values; wen is don't-care when gwen = 0.
- **Request hold rule:** requests are not queued. A requester must hold req and its payload stable until the grant, and must drop req or present new payload in the cycle after the grant.

## Timing
- **Grant latency:** grant is combinational in cycle N; the array write is presented in cycle N+1 for exactly one cycle.
- **Back-to-back:** consecutive grants, including to the same index, are allowed.
- **Reset values:** all registered outputs and the age counter are 0 on `cpurst` assertion, asynchronously. While reset is asserted, grants are forced to 0.
- **Reset mid-operation:** if reset is asserted in cycle N+1 with a write pending, that write is dropped; the requester re-requests after reset.
- **busy and req together:** when busy and a request coincide, no grant is given and the age counter does not advance.
- **Counter saturation:** the counter stays at `AGE_MAX` while icc is still deferred (e.g. by busy).
- **Simultaneous requests:** with all three requests high, each unbusy cycle grants exactly one requester by current priority.

## Structure
- **Shared LSU package:**
  - requester encoding constants (`SNQ` = 0, `RB` = 1, `ICC` = 2);
  - `DC_TAG_W` = 26, `DC_DIRTY_W` = 7, `IDX_W`.
- **Sub-module `ct_lsu_dcache_arb_age`:** the saturating age counter and promotion flag, reusable for other array arbiters.
- **Top level:** priority mux plus write-stage register.

## Test plan
- **Single request:** `rb_req` with idx = 0x1A5, tag_wen = 2'b01, dirty_wen = 7'h07, dirty_din = 7'h01 → `rb_grnt` in cycle 0. Cycle 1: `dcache_idx` = 0x1A5, both gwen = 1, dirty_din = 0x01, `compare_dcwp_sw_inst` = 0. Cycle 2: both gwen = 0.
- **Three-way contention:** all three requests held continuously → grants snq, rb, icc in that order once each requester drops after its grant; exactly one grant per cycle.
- **Starvation promotion:** icc_req held while snq and rb re-request every cycle → icc granted on the 8th unbusy cycle (counter reaches 7), ahead of snq; counter returns to 0; `compare_dcwp_sw_inst` = 1 the following cycle.
- **Busy stall:** `dcache_arb_busy` = 1 for 5 cycles with `snq_req` high → no grant, gwen stays 0, age counter unchanged; grant in the first cycle busy drops.
- **Dirty-only write:** granted request with tag_wen = 0 and dirty_wen = 7'h38 → next cycle `dcache_tag_gwen` = 0, `dcache_dirty_gwen` = 1.
- **Reset during pending write:** grant in cycle N, reset asserted in N+1 → gwen outputs 0 immediately, age counter 0, no write reaches the array.
